// File: rtl/ar_srl_fifo_lvl.sv
// SRL FIFO with registered head, occupancy count and AFULL/AEMPTY; ARSRL_ERRFLAG_EN adds sticky OVF/UNF.
// Latency: ENQ into empty FIFO shows at D_OUT two edges later; COUNT/AFULL/AEMPTY update on the accepting edge.
// Backpressure: ENQ ignored while FULL_N=0, DEQ ignored while EMPTY_N=0; both are gated internally.
module ar_srl_fifo_lvl #(
   parameter int width     = 128,
   parameter int l2depth   = 5,
   parameter int afull_th  = 28,
   parameter int aempty_th = 2
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               CLR,
   input  logic               ENQ,
   input  logic [width-1:0]   D_IN,
   input  logic               DEQ,
   output logic [width-1:0]   D_OUT,
   output logic               FULL_N,
   output logic               EMPTY_N,
   output logic [l2depth:0]   COUNT,
   output logic               AFULL,
   output logic               AEMPTY,
   output logic               OVF,
   output logic               UNF
);

   localparam int depth = 2 ** l2depth;
   localparam int cw    = l2depth + 1;
   localparam logic [cw-1:0] depth_c = cw'(depth);
   localparam logic [cw-1:0] af_c    = cw'(afull_th);
   localparam logic [cw-1:0] ae_c    = cw'(aempty_th);

   logic [width-1:0]   dat [depth];
   logic [width-1:0]   d_out_r;
   logic [cw-1:0]      pos, pos_next, count_r, count_next;
   logic               sempty, sfull, dempty, afull_r, aempty_r;
   logic               enq_ok, deq_ok, sdx;
   logic [l2depth-1:0] rd_idx;

   always_comb begin
      enq_ok     = ENQ & ~sfull;
      deq_ok     = DEQ & ~dempty;
      sdx        = ~sempty & (dempty | deq_ok);
      // pos==depth wraps to index depth-1 in the low bits, which is the oldest entry
      rd_idx     = pos[l2depth-1:0] - l2depth'(1);
      pos_next   = pos;
      if (enq_ok & ~sdx)
         pos_next = pos + cw'(1);
      else if (sdx & ~enq_ok)
         pos_next = pos - cw'(1);
      count_next = count_r + cw'(enq_ok) - cw'(deq_ok);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pos      <= '0;
         sempty   <= 1'b1;
         sfull    <= 1'b0;
         dempty   <= 1'b1;
         count_r  <= '0;
         afull_r  <= 1'b0;
         aempty_r <= 1'b1;
      end else if (CLR) begin
         pos      <= '0;
         sempty   <= 1'b1;
         sfull    <= 1'b0;
         dempty   <= 1'b1;
         count_r  <= '0;
         afull_r  <= 1'b0;
         aempty_r <= 1'b1;
      end else begin
         pos      <= pos_next;
         sempty   <= (pos_next == '0);
         sfull    <= (pos_next == depth_c);
         if (sdx)
            dempty <= 1'b0;
         else if (deq_ok & sempty)
            dempty <= 1'b1;
         count_r  <= count_next;
         afull_r  <= (count_next >= af_c);
         aempty_r <= (count_next <= ae_c);
      end
   end

   // Storage is deliberately unreset so it maps onto shift-register primitives.
   always_ff @(posedge CLK) begin
      if (!CLR && enq_ok) begin
         for (int i = depth - 1; i > 0; i--)
            dat[i] <= dat[i-1];
         dat[0] <= D_IN;
      end
      if (!CLR && sdx)
         d_out_r <= dat[rd_idx];
   end

`ifdef ARSRL_ERRFLAG_EN
   logic ovf_r, unf_r;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else if (CLR) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         if (ENQ & sfull)
            ovf_r <= 1'b1;
         if (DEQ & dempty)
            unf_r <= 1'b1;
      end
   end

   assign OVF = ovf_r;
   assign UNF = unf_r;
`else
   assign OVF = 1'b0;
   assign UNF = 1'b0;
`endif

   assign D_OUT   = d_out_r;
   assign FULL_N  = ~sfull;
   assign EMPTY_N = ~dempty;
   assign COUNT   = count_r;
   assign AFULL   = afull_r;
   assign AEMPTY  = aempty_r;

endmodule

// File: tb/tb_ar_srl_fifo_lvl.sv
// Scoreboard bench for ar_srl_fifo_lvl at default parameters (width 128, depth 32, CAP 33).
module tb_ar_srl_fifo_lvl;

   localparam int W     = 128;
   localparam int DEPTH = 32;

   logic          CLK = 1'b0;
   logic          RST_N, CLR, ENQ, DEQ;
   logic [W-1:0]  D_IN;
   logic [W-1:0]  D_OUT;
   logic          FULL_N, EMPTY_N, AFULL, AEMPTY, OVF, UNF;
   logic [5:0]    COUNT;

   int            errors = 0;
   int            checks = 0;

   logic [W-1:0]  sb [$];
   int            m_pos, m_count;
   bit            m_dv, m_ovf, m_unf;

   ar_srl_fifo_lvl dut (
      .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .ENQ(ENQ), .D_IN(D_IN), .DEQ(DEQ),
      .D_OUT(D_OUT), .FULL_N(FULL_N), .EMPTY_N(EMPTY_N), .COUNT(COUNT),
      .AFULL(AFULL), .AEMPTY(AEMPTY), .OVF(OVF), .UNF(UNF)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_count = 0; m_dv = 0; m_ovf = 0; m_unf = 0;
      sb.delete();
   endtask

   task automatic check_outputs();
      chk("count",   W'(COUNT),   W'(m_count));
      chk("full_n",  W'(FULL_N),  W'(m_pos != DEPTH));
      chk("empty_n", W'(EMPTY_N), W'(m_dv));
      chk("afull",   W'(AFULL),   W'(m_count >= 28));
      chk("aempty",  W'(AEMPTY),  W'(m_count <= 2));
`ifdef ARSRL_ERRFLAG_EN
      chk("ovf", W'(OVF), W'(m_ovf));
      chk("unf", W'(UNF), W'(m_unf));
`else
      chk("ovf", W'(OVF), '0);
      chk("unf", W'(UNF), '0);
`endif
   endtask

   // Called at a falling edge: drive, predict, clock, compare.
   task automatic step(input bit en, input logic [W-1:0] din, input bit de);
      bit e_ok, d_ok, sdx;
      logic [W-1:0] exp;
      ENQ = en; D_IN = din; DEQ = de;
      e_ok = en && (m_pos != DEPTH);
      d_ok = de && m_dv;
      if (d_ok) begin
         exp = sb.pop_front();
         chk("dout", D_OUT, exp);
      end
      if (e_ok) sb.push_back(din);
      if (en && !e_ok) m_ovf = 1;
      if (de && !m_dv) m_unf = 1;
      sdx = (m_pos != 0) && (!m_dv || d_ok);
      if (e_ok && !sdx) m_pos++;
      else if (sdx && !e_ok) m_pos--;
      if (sdx) m_dv = 1;
      else if (d_ok) m_dv = 0;
      m_count = m_count + int'(e_ok) - int'(d_ok);
      @(posedge CLK); #1;
      check_outputs();
      @(negedge CLK);
      ENQ = 0; DEQ = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) step(0, '0, 1);
   endtask

   initial begin
      RST_N = 0; CLR = 0; ENQ = 0; DEQ = 0; D_IN = '0;
      model_reset();
      repeat (3) @(negedge CLK);
      check_outputs();
      RST_N = 1;
      @(negedge CLK);

      // asynchronous reset in the middle of traffic
      for (int i = 0; i < 5; i++) step(1, W'(i + 100), 0);
      #2 RST_N = 0;
      #1;
      chk("rst_full_n",  W'(FULL_N),  W'(1));
      chk("rst_empty_n", W'(EMPTY_N), W'(0));
      chk("rst_count",   W'(COUNT),   W'(0));
      chk("rst_aempty",  W'(AEMPTY),  W'(1));
      chk("rst_afull",   W'(AFULL),   W'(0));
      model_reset();
      @(negedge CLK);
      RST_N = 1;
      @(negedge CLK);

      // first-item latency
      step(1, W'(8'hA5), 0);
      chk("lat_count1",   W'(COUNT),   W'(1));
      chk("lat_empty_n0", W'(EMPTY_N), W'(0));
      step(0, '0, 0);
      chk("lat_empty_n1", W'(EMPTY_N), W'(1));
      chk("lat_dout",     D_OUT,       W'(8'hA5));
      drain();

      // fill beyond capacity
      for (int i = 0; i < 40; i++) step(1, W'(i), 0);
      chk("fill_count",  W'(COUNT),  W'(33));
      chk("fill_full_n", W'(FULL_N), W'(0));
      chk("fill_afull",  W'(AFULL),  W'(1));

      // full with simultaneous ENQ and DEQ: only DEQ takes effect
      step(1, W'(999), 1);
      chk("fdq_count",  W'(COUNT),  W'(32));
      chk("fdq_full_n", W'(FULL_N), W'(1));
      drain();
      chk("drained_count", W'(COUNT), W'(0));

      // empty with simultaneous ENQ and DEQ: only ENQ takes effect
      step(1, W'(77), 1);
      chk("edq_count", W'(COUNT), W'(1));
      drain();

      // random streaming
      for (int i = 0; i < 10000; i++)
         step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      drain();

      // synchronous clear with ten items held
      for (int i = 0; i < 10; i++) step(1, W'(i + 500), 0);
      chk("pre_clr_count", W'(COUNT), W'(10));
      CLR = 1;
      @(posedge CLK); #1;
      model_reset();
      check_outputs();
      @(negedge CLK);
      CLR = 0;
      step(0, '0, 1);
      chk("clr_count", W'(COUNT), W'(0));
`ifdef ARSRL_ERRFLAG_EN
      chk("clr_unf", W'(UNF), W'(1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
